// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one imem read at a time,
// and registers the returned word with its address for decode.
//
// state   | meaning
// S_IDLE  | out of reset, first request issued on the next edge
// S_FETCH | imem_req high, imem_addr held until imem_rvalid
// S_HOLD  | instruction presented to decode, waiting for !stall or redirect
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        drop_q, drop_d;
  logic [31:0] target_al;

  assign target_al = {pc_target[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;
    drop_d     = drop_q;
    case (state_q)
      S_IDLE: begin
        req_d   = 1'b1;
        state_d = S_FETCH;
        if (pc_src) begin
          pc_d   = target_al;
          addr_d = target_al;
        end else begin
          addr_d = pc_q;
        end
      end
      S_FETCH: begin
        if (imem_rvalid) begin
          if (!drop_q && !pc_src) begin
            instr_d    = imem_rdata;
            pc_out_d   = addr_q;
            pc_plus4_d = addr_q + 32'd4;
            pc_d       = addr_q + 32'd4;
            valid_d    = 1'b1;
            req_d      = 1'b0;
            state_d    = S_HOLD;
          end else begin
            // Stale response: retire it and start the redirected fetch right away.
            drop_d = 1'b0;
            if (pc_src) begin
              pc_d   = target_al;
              addr_d = target_al;
            end else begin
              addr_d = pc_q;
            end
          end
        end else if (pc_src) begin
          drop_d = 1'b1;
          pc_d   = target_al;
        end
      end
      S_HOLD: begin
        if (pc_src) begin
          valid_d = 1'b0;
          pc_d    = target_al;
          req_d   = 1'b1;
          addr_d  = target_al;
          state_d = S_FETCH;
        end else if (!stall) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= 32'd0;
      valid_q    <= 1'b0;
      instr_q    <= 32'd0;
      pc_out_q   <= 32'd0;
      pc_plus4_q <= 32'd0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
      drop_q     <= drop_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_plus4_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: imem responses are driven by hand
// with fixed latencies and every output is compared against hand-computed values.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;

  int errors = 0;
  int checks = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_1000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
    .instr_valid(instr_valid), .instruction(instruction),
    .pc_out(pc_out), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    stall = 1'b0; pc_src = 1'b0; pc_target = 32'd0;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if ({instruction, pc_out, pc_plus4} !== 96'd0) begin errors++;
      $display("FAIL reset_outs got %h %h %h exp 0 0 0", instruction, pc_out, pc_plus4); end
    reset = 1'b0;
  endtask

  task automatic test_basic_fetch();
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000) begin errors++;
      $display("FAIL first_req got req=%b addr=%h exp 1 00001000", imem_req, imem_addr); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++;
      $display("FAIL basic_valid got valid=%b req=%b exp 1 0", instr_valid, imem_req); end
    checks++; if (instruction !== 32'h0050_0093) begin errors++;
      $display("FAIL basic_instr got %h exp 00500093", instruction); end
    checks++; if (pc_out !== 32'h1000 || pc_plus4 !== 32'h1004) begin errors++;
      $display("FAIL basic_pc got %h %h exp 00001000 00001004", pc_out, pc_plus4); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instruction !== 32'h0050_0093 ||
                    pc_out !== 32'h1000 || pc_plus4 !== 32'h1004) begin errors++;
        $display("FAIL stall_hold[%0d] got v=%b req=%b %h %h %h", i, instr_valid, imem_req,
                 instruction, pc_out, pc_plus4); end
    end
    stall = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h1004) begin errors++;
      $display("FAIL stall_release got v=%b req=%b addr=%h exp 0 1 00001004",
               instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_redirect_in_flight();
    pc_src = 1'b1; pc_target = 32'h2003;
    tick();
    pc_src = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1004 || instr_valid !== 1'b0) begin errors++;
      $display("FAIL drop_hold1 got req=%b addr=%h v=%b exp 1 00001004 0", imem_req, imem_addr, instr_valid); end
    tick();
    checks++; if (imem_addr !== 32'h1004) begin errors++;
      $display("FAIL drop_hold2 got addr=%h exp 00001004", imem_addr); end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h2000) begin errors++;
      $display("FAIL drop_refetch got v=%b req=%b addr=%h exp 0 1 00002000", instr_valid, imem_req, imem_addr); end
    tick(); tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instruction !== 32'h1111_1111 ||
                  pc_out !== 32'h2000 || pc_plus4 !== 32'h2004) begin errors++;
      $display("FAIL redirect_deliver got v=%b %h %h %h exp 1 11111111 00002000 00002004",
               instr_valid, instruction, pc_out, pc_plus4); end
  endtask

  task automatic test_hold_redirect();
    stall = 1'b1; pc_src = 1'b1; pc_target = 32'h3000;
    tick();
    stall = 1'b0; pc_src = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3000) begin errors++;
      $display("FAIL hold_redirect got v=%b req=%b addr=%h exp 0 1 00003000", instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444; pc_src = 1'b1; pc_target = 32'hFFFF_FFFF;
    tick();
    imem_rvalid = 1'b0; pc_src = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++;
      $display("FAIL rvalid_redirect got v=%b req=%b addr=%h exp 0 1 fffffffc", instr_valid, imem_req, imem_addr); end
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin errors++;
      $display("FAIL wrap_pc got v=%b %h %h exp 1 fffffffc 00000000", instr_valid, pc_out, pc_plus4); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++;
      $display("FAIL wrap_next got req=%b addr=%h exp 1 00000000", imem_req, imem_addr); end
  endtask

  task automatic test_double_redirect();
    pc_src = 1'b1; pc_target = 32'h4000;
    tick();
    pc_target = 32'h5000;
    tick();
    pc_src = 1'b0;
    checks++; if (imem_addr !== 32'h0) begin errors++;
      $display("FAIL double_hold got addr=%h exp 00000000", imem_addr); end
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
    tick();
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h5000) begin errors++;
      $display("FAIL double_refetch got v=%b addr=%h exp 0 00005000", instr_valid, imem_addr); end
    tick();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h5000 || instruction !== 32'h5555_5555) begin errors++;
      $display("FAIL double_deliver got v=%b %h %h exp 1 00005000 55555555", instr_valid, pc_out, instruction); end
  endtask

  task automatic test_reset_mid_fetch();
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h5004) begin errors++;
      $display("FAIL pre_reset_req got req=%b addr=%h exp 1 00005004", imem_req, imem_addr); end
    reset = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    tick();
    reset = 1'b0; imem_rvalid = 1'b0;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instruction !== 32'h0) begin errors++;
      $display("FAIL reset_mid got req=%b v=%b instr=%h exp 0 0 0", imem_req, instr_valid, instruction); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000) begin errors++;
      $display("FAIL reset_refetch got req=%b addr=%h exp 1 00001000", imem_req, imem_addr); end
  endtask

  task automatic test_idle_redirect();
    reset = 1'b1;
    tick();
    reset = 1'b0; pc_src = 1'b1; pc_target = 32'h6002;
    tick();
    pc_src = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h6000) begin errors++;
      $display("FAIL idle_redirect got req=%b addr=%h exp 1 00006000", imem_req, imem_addr); end
    imem_rvalid = 1'b1; imem_rdata = 32'h7777_7777;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (pc_out !== 32'h6000 || pc_plus4 !== 32'h6004) begin errors++;
      $display("FAIL idle_redirect_pc got %h %h exp 00006000 00006004", pc_out, pc_plus4); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_in_flight();
    test_hold_redirect();
    test_wrap();
    test_double_redirect();
    test_reset_mid_fetch();
    test_idle_redirect();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
